// File: rtl/imem_fill_resp_if.sv
// Line-fill bus between the instruction cache, this responder and the narrow memory port.
// The DUT uses the slave view; the environment (cache + memory) drives the master view.
interface imem_fill_resp_if #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BEAT_W  = 64,
    parameter int unsigned BLK_LEN = 59
);
    logic [BLK_LEN-1:0] b_addr_i;
    logic               b_rd_i;
    logic [LINE_W-1:0]  b_data_i;
    logic               b_dv_i;
    logic [63:0]        m_addr;
    logic               m_rd;
    logic               m_rdy;
    logic [BEAT_W-1:0]  m_data;
    logic               m_dv;

    modport master (
        output b_addr_i, b_rd_i, m_rdy, m_data, m_dv,
        input  b_data_i, b_dv_i, m_addr, m_rd
    );

    modport slave (
        input  b_addr_i, b_rd_i, m_rdy, m_data, m_dv,
        output b_data_i, b_dv_i, m_addr, m_rd
    );
endinterface

// File: rtl/imem_fill_resp.sv
// I-cache line-fill responder: splits a line request into ascending beat reads on a
// pipelined memory port, assembles the returned beats and delivers the line with a one-cycle pulse.
module imem_fill_resp #(
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned BEAT_W    = 64,
    parameter int unsigned BLK_LEN   = 59,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_fill_resp_if.slave bus
);
    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam int unsigned LOFF  = 64 - BLK_LEN;
    localparam int unsigned BOFF  = $clog2(BEAT_W / 8);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, HOLD} state_e;

    state_e             state_q, state_d;
    logic [BLK_LEN-1:0] blk_q, blk_d;
    logic [CNT_W-1:0]   iss_q, iss_d;
    logic [CNT_W-1:0]   rcv_q, rcv_d;
    logic [CNT_W-1:0]   outst;
    logic               abort_q, abort_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               b_dv_q;
    logic               m_rd;

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        abort_d = abort_q;
        line_d  = line_q;
        m_rd    = 1'b0;
        outst   = iss_q - rcv_q;

        // A beat with nothing outstanding is a protocol error and is dropped.
        if ((state_q == ISSUE || state_q == DRAIN) && bus.m_dv && outst != '0) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (rcv_q == CNT_W'(k)) line_d[k*BEAT_W +: BEAT_W] = bus.m_data;
            end
            rcv_d = rcv_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.b_rd_i) begin
                    blk_d   = bus.b_addr_i;
                    iss_d   = '0;
                    rcv_d   = '0;
                    abort_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.b_rd_i) begin
                    abort_d = 1'b1;
                    state_d = DRAIN;
                end else begin
                    m_rd = (outst < CNT_W'(MAX_OUTST));
                    if (m_rd && bus.m_rdy) begin
                        iss_d = iss_q + CNT_W'(1);
                        if (iss_q == CNT_W'(BEATS - 1)) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Decide on next-cycle counts so the final beat moves straight on.
                if (abort_q) begin
                    if (iss_d == rcv_d) state_d = IDLE;
                end else if (rcv_d == CNT_W'(BEATS)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = HOLD;
            HOLD:    if (!bus.b_rd_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            blk_q   <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
            abort_q <= 1'b0;
            line_q  <= '0;
            b_dv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            abort_q <= abort_d;
            line_q  <= line_d;
            b_dv_q  <= (state_d == DONE);
        end
    end

    assign bus.m_rd     = m_rd;
    assign bus.m_addr   = {blk_q, {LOFF{1'b0}}} | ((64'(iss_q) & 64'(BEATS - 1)) << BOFF);
    assign bus.b_dv_i   = b_dv_q;
    assign bus.b_data_i = line_q;
endmodule
